// File: rtl/compare_sequencer.sv
// compare_sequencer
//
// Purpose:
//   Compares two W-bit operands (W = 4*NIBBLES) one nibble at a time on an
//   external shared 4-bit comparator. It starts at the most significant
//   nibble and stops at the first nibble that differs. The result reports
//   the magnitude relation and the number of nibbles examined. The result
//   also flags an error if the comparator returns an illegal flag pattern.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    operand pair offered
//   req_ready_o    block can accept an operand pair (IDLE only)
//   op_a_i/op_b_i  operands, sampled on acceptance
//   cmp_a_o/cmp_b_o  nibble pair driven to the shared comparator (0 when idle)
//   cmp_gt_i/cmp_lt_i/cmp_eq_i  comparator flags for the current nibble pair
//   res_valid_o    result available
//   res_ready_i    consumer accepts result
//   res_gt_o/res_lt_o/res_eq_o  final relation of A vs B
//   res_err_o      comparator returned an illegal flag combination
//   res_cycles_o   number of nibbles examined (1..NIBBLES)

module compare_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [4*NIBBLES-1:0]   op_a_i,
    input  logic [4*NIBBLES-1:0]   op_b_i,
    output logic [3:0]             cmp_a_o,
    output logic [3:0]             cmp_b_o,
    input  logic                   cmp_gt_i,
    input  logic                   cmp_lt_i,
    input  logic                   cmp_eq_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   res_gt_o,
    output logic                   res_lt_o,
    output logic                   res_eq_o,
    output logic                   res_err_o,
    output logic [2:0]             res_cycles_o
);

    localparam int         W        = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     cnt_q, cnt_d;
    // Result flags packed as {gt, lt, eq, err}
    logic [3:0]     res_q, res_d;
    logic [3:0]     nibA, nibB;

    // Selected nibble of each registered operand, chosen by the current index
    always_comb begin
        nibA = 4'h0;
        nibB = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == 3'(i)) begin
                nibA = a_q[4*i +: 4];
                nibB = b_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        req_ready_o = 1'b0;
        res_valid_o = 1'b0;
        cmp_a_o     = 4'h0;
        cmp_b_o     = 4'h0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    idx_d   = LAST_IDX;
                    cnt_d   = 3'd0;
                    res_d   = 4'b0000;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                cmp_a_o = nibA;
                cmp_b_o = nibB;
                cnt_d   = cnt_q + 3'd1;
                // Exactly one flag must be set; anything else is a comparator fault
                case ({cmp_gt_i, cmp_lt_i, cmp_eq_i})
                    3'b100: begin
                        res_d   = 4'b1000;
                        state_d = DONE;
                    end
                    3'b010: begin
                        res_d   = 4'b0100;
                        state_d = DONE;
                    end
                    3'b001: begin
                        if (idx_q == 3'd0) begin
                            res_d   = 4'b0010;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q - 3'd1;
                        end
                    end
                    default: begin
                        res_d   = 4'b0001;
                        state_d = DONE;
                    end
                endcase
            end

            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    res_d   = 4'b0000;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result fields are gated so they read as zero whenever no result is offered
    assign res_gt_o     = res_valid_o & res_q[3];
    assign res_lt_o     = res_valid_o & res_q[2];
    assign res_eq_o     = res_valid_o & res_q[1];
    assign res_err_o    = res_valid_o & res_q[0];
    assign res_cycles_o = res_valid_o ? cnt_q : 3'd0;

endmodule

// File: tb/tb_compare_sequencer.sv
// tb_compare_sequencer
//
// Purpose:
//   Self-checking bench for compare_sequencer with NIBBLES=4. It contains a
//   behavioural 4-bit comparator, which can be forced to report an illegal
//   flag pattern. Expected results are derived from whole-operand
//   arithmetic and pushed into a queue. An independent monitor checks each
//   presented result, its latency, the comparator nibble sequence and the
//   idle/done output invariants.
//
// Ports: none (top-level bench)

module tb_compare_sequencer;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic          gt;
        logic          lt;
        logic          eq;
        logic          err;
        logic [2:0]    cycles;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            acceptAt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          reqValid;
    logic          reqReady;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [3:0]    cmpA;
    logic [3:0]    cmpB;
    logic          cmpGt;
    logic          cmpLt;
    logic          cmpEq;
    logic          resValid;
    logic          resReady;
    logic          resGt;
    logic          resLt;
    logic          resEq;
    logic          resErr;
    logic [2:0]    resCycles;

    logic          forceErr;
    logic          monOn;
    logic          handshakePrev;
    logic          seenValid;
    int            holdTarget;
    int            validCnt;
    int            cycleCount;
    int            checks;
    int            errors;
    exp_t          expQ[$];

    compare_sequencer #(.NIBBLES(NIB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .op_a_i       (opA),
        .op_b_i       (opB),
        .cmp_a_o      (cmpA),
        .cmp_b_o      (cmpB),
        .cmp_gt_i     (cmpGt),
        .cmp_lt_i     (cmpLt),
        .cmp_eq_i     (cmpEq),
        .res_valid_o  (resValid),
        .res_ready_i  (resReady),
        .res_gt_o     (resGt),
        .res_lt_o     (resLt),
        .res_eq_o     (resEq),
        .res_err_o    (resErr),
        .res_cycles_o (resCycles)
    );

    // Behavioural shared comparator; forceErr produces the illegal gt=lt=1 pattern
    assign cmpGt = forceErr ? 1'b1 : (cmpA > cmpB);
    assign cmpLt = forceErr ? 1'b1 : (cmpA < cmpB);
    assign cmpEq = forceErr ? 1'b0 : (cmpA == cmpB);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference: relation from whole operands, nibbles examined = leading equal nibbles + 1
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic err, input int acc);
        exp_t e;
        int   k;
        e = '0;
        e.a = a;
        e.b = b;
        e.acceptAt = acc;
        if (err) begin
            e.err    = 1'b1;
            e.cycles = 3'd1;
        end else begin
            k = 1;
            for (int i = NIB - 1; i > 0; i--) begin
                if (((a >> (4*i)) & 16'hF) == ((b >> (4*i)) & 16'hF)) k++;
                else break;
            end
            e.cycles = 3'(k);
            e.gt = (a > b);
            e.lt = (a < b);
            e.eq = (a == b);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cycleCount);
        end
    endtask

    // Consumer: random backpressure, or hold res_ready low for holdTarget DONE cycles
    always @(posedge clk) begin
        #2;
        if (resValid) begin
            resReady = (validCnt >= holdTarget);
            validCnt++;
        end else begin
            validCnt = 0;
            resReady = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks outputs against the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (monOn) begin
            if (handshakePrev) begin
                checkOutput("idle_after_ack_ready", 32'(reqReady), 32'd1);
                checkOutput("idle_after_ack_valid", 32'(resValid), 32'd0);
            end
            handshakePrev = 1'b0;
            if (resValid) begin
                checkOutput("done_req_ready", 32'(reqReady), 32'd0);
                checkOutput("done_cmp_zero", {24'd0, cmpA, cmpB}, 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got res_valid=1, expected none pending");
                end else begin
                    e = expQ[0];
                    if (!seenValid) begin
                        checkOutput("latency", 32'(cycleCount - e.acceptAt), 32'(e.cycles));
                        seenValid = 1'b1;
                    end
                    checkOutput("res_flags", {28'd0, resGt, resLt, resEq, resErr},
                                {28'd0, e.gt, e.lt, e.eq, e.err});
                    checkOutput("res_cycles", 32'(resCycles), 32'(e.cycles));
                    if (resReady) begin
                        void'(expQ.pop_front());
                        seenValid     = 1'b0;
                        handshakePrev = 1'b1;
                    end
                end
            end else begin
                checkOutput("res_zero_when_invalid", {25'd0, resGt, resLt, resEq, resErr, resCycles}, 32'd0);
                if (reqReady) begin
                    checkOutput("idle_cmp_zero", {24'd0, cmpA, cmpB}, 32'd0);
                end else if (expQ.size() > 0) begin
                    e = expQ[0];
                    idx = NIB - 1 - (cycleCount - e.acceptAt);
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL compare_overrun: got still comparing, expected result by now");
                    end else begin
                        checkOutput("cmp_nibbles", {24'd0, cmpA, cmpB},
                                    {24'd0, 4'((e.a >> (4*idx)) & 16'hF), 4'((e.b >> (4*idx)) & 16'hF)});
                    end
                end
            end
        end
    end

    // Offer one operand pair; the expectation is queued at the acceptance edge
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic err, input int hold);
        int waitN;
        waitN = 0;
        @(negedge clk);
        while (!reqReady) begin
            @(negedge clk);
            waitN++;
            if (waitN > 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL req_ready_timeout: got 0, expected 1 within 100 cycles");
                return;
            end
        end
        reqValid   = 1'b1;
        opA        = a;
        opB        = b;
        holdTarget = hold;
        @(posedge clk);
        #1;
        expQ.push_back(model(a, b, err, cycleCount));
        forceErr = err;
        reqValid = 1'b0;
        opA      = W'($urandom);
        opB      = W'($urandom);
        @(posedge clk);
        #1;
        forceErr = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           waitN;
        checks        = 0;
        errors        = 0;
        monOn         = 1'b0;
        handshakePrev = 1'b0;
        seenValid     = 1'b0;
        forceErr      = 1'b0;
        holdTarget    = 0;
        validCnt      = 0;
        resReady      = 1'b0;
        reqValid      = 1'b0;
        opA           = '0;
        opB           = '0;
        rst           = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(reqReady), 32'd1);
        checkOutput("reset_res_valid", 32'(resValid), 32'd0);
        checkOutput("reset_res_fields", {25'd0, resGt, resLt, resEq, resErr, resCycles}, 32'd0);
        checkOutput("reset_cmp_zero", {24'd0, cmpA, cmpB}, 32'd0);
        rst   = 1'b0;
        monOn = 1'b1;

        // Directed cases: full-length equal, MSB early exit, second-nibble exit, long stall, forced error
        applyStimulus(16'h1234, 16'h1234, 1'b0, 0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1);
        applyStimulus(16'h12F0, 16'h1300, 1'b0, 0);
        applyStimulus(16'hABCD, 16'hAB00, 1'b0, 5);
        applyStimulus(16'h5555, 16'h5555, 1'b1, 0);
        waitDrain();

        // Reset during the second COMPARE cycle aborts the comparison
        @(negedge clk);
        waitN = 0;
        while (!reqReady && waitN < 100) begin
            @(negedge clk);
            waitN++;
        end
        reqValid = 1'b1;
        opA      = 16'h1234;
        opB      = 16'h1235;
        @(posedge clk);
        #1;
        expQ.push_back(model(16'h1234, 16'h1235, 1'b0, cycleCount));
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(expQ.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_req_ready", 32'(reqReady), 32'd1);
        checkOutput("abort_res_valid", 32'(resValid), 32'd0);
        checkOutput("abort_cmp_zero", {24'd0, cmpA, cmpB}, 32'd0);
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_no_result", 32'(resValid), 32'd0);
        end
        applyStimulus(16'h1234, 16'h1235, 1'b0, 0);
        waitDrain();

        // Randomized operands biased toward shared high-order nibbles
        for (int t = 0; t < 60; t++) begin
            a = W'($urandom);
            case ($urandom_range(0, 2))
                0: b = W'($urandom);
                1: b = a;
                default: b = a ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
            endcase
            applyStimulus(a, b, 1'b0, $urandom_range(0, 3));
        end
        waitDrain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
